// File: rtl/vector_pkg.sv
// Shared types and constants for the double-buffered vector display list.
package vector_pkg;
  typedef enum logic {BUF_FILL, BUF_PENDING} vbuf_state_t;
  localparam VBUF_BLANK_WORD = '0;
endpackage

// File: rtl/vector_list_bank.sv
// One display-list bank: synchronous write port, asynchronous read port.
module vector_list_bank #(
  parameter int ADDRESSWIDTH = 8,
  parameter int DATAWIDTH    = 18
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [ADDRESSWIDTH-1:0] wr_addr,
  input  logic [DATAWIDTH-1:0]    wr_data,
  input  logic [ADDRESSWIDTH-1:0] rd_addr,
  output logic [DATAWIDTH-1:0]    rd_data
);
  logic [DATAWIDTH-1:0] mem [2**ADDRESSWIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/vector_list_buffer.sv
// Double-buffered vector list RAM: writer fills the back bank, display reads the
// front bank, and banks swap only on a frame boundary after a commit.
module vector_list_buffer import vector_pkg::*; #(
  parameter int ADDRESSWIDTH = 8,
  parameter int DATAWIDTH    = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDRESSWIDTH-1:0] wr_addr,
  input  logic [DATAWIDTH-1:0]    wr_data,
  input  logic                    wr_commit,
  output logic                    wr_ready,
  output logic                    wr_err,
  input  logic [ADDRESSWIDTH-1:0] rd_addr,
  output logic [DATAWIDTH-1:0]    rd_data,
  input  logic                    frame_drawn,
  output logic                    front_sel,
  output logic                    front_valid,
  output logic                    swap_done,
  output logic [7:0]              frame_cnt
);
  vbuf_state_t          state;
  logic                 wr_fire;
  logic [DATAWIDTH-1:0] rd_data0;
  logic [DATAWIDTH-1:0] rd_data1;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Writes are only accepted while filling and always target the back bank.
  assign wr_fire = (state == BUF_FILL) && wr_en;

  vector_list_bank #(.ADDRESSWIDTH(ADDRESSWIDTH), .DATAWIDTH(DATAWIDTH)) u_bank0 (
    .clk     (clk),
    .wr_en   (wr_fire && front_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data0)
  );

  vector_list_bank #(.ADDRESSWIDTH(ADDRESSWIDTH), .DATAWIDTH(DATAWIDTH)) u_bank1 (
    .clk     (clk),
    .wr_en   (wr_fire && !front_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BUF_FILL;
      wr_ready    <= 1'b1;
      wr_err      <= 1'b0;
      front_sel   <= 1'b0;
      front_valid <= 1'b0;
      swap_done   <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      wr_err    <= 1'b0;
      swap_done <= 1'b0;
      case (state)
        BUF_FILL: begin
          if (wr_commit) begin
            state    <= BUF_PENDING;
            wr_ready <= 1'b0;
          end
          // A commit arriving with frame_drawn still waits for the next frame.
          if (frame_drawn) frame_cnt <= sat_inc(frame_cnt);
        end
        BUF_PENDING: begin
          wr_err <= wr_en || wr_commit;
          if (frame_drawn) begin
            state       <= BUF_FILL;
            wr_ready    <= 1'b1;
            front_sel   <= !front_sel;
            front_valid <= 1'b1;
            swap_done   <= 1'b1;
            frame_cnt   <= 8'd0;
          end
        end
        default: begin
          state    <= BUF_FILL;
          wr_ready <= 1'b1;
        end
      endcase
    end
  end

  // Until the first swap the display sees a blank list rather than stale RAM.
  assign rd_data = !front_valid ? DATAWIDTH'(VBUF_BLANK_WORD)
                 : (front_sel ? rd_data1 : rd_data0);
endmodule

// File: tb/tb_vector_list_buffer.sv
// Self-checking bench for vector_list_buffer with a list-level reference model.
module tb_vector_list_buffer;
  localparam int AW = 8;
  localparam int DW = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_commit = 1'b0;
  logic          wr_ready;
  logic          wr_err;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          frame_drawn = 1'b0;
  logic          front_sel;
  logic          front_valid;
  logic          swap_done;
  logic [7:0]    frame_cnt;

  int checks = 0;
  int errors = 0;

  vector_list_buffer #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_commit(wr_commit), .wr_ready(wr_ready), .wr_err(wr_err),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_drawn(frame_drawn),
    .front_sel(front_sel), .front_valid(front_valid), .swap_done(swap_done),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: two lists, which one is shown, and whether a commit waits.
  logic [DW-1:0] mlist [2][256];
  bit            mknown [2][256];
  bit            mshown;
  bit            mvalid;
  bit            mwaiting;
  int            mframes;
  bit            merr;
  bit            mswapped;

  task automatic model_reset();
    mshown = 0; mvalid = 0; mwaiting = 0; mframes = 0; merr = 0; mswapped = 0;
  endtask

  task automatic model_step();
    bit was_waiting;
    was_waiting = mwaiting;
    merr = 0;
    mswapped = 0;
    if (!was_waiting) begin
      if (wr_en) begin
        mlist[!mshown][wr_addr] = wr_data;
        mknown[!mshown][wr_addr] = 1;
      end
      if (wr_commit) mwaiting = 1;
      if (frame_drawn && mframes < 255) mframes++;
    end else begin
      merr = wr_en || wr_commit;
      if (frame_drawn) begin
        mshown = !mshown;
        mvalid = 1;
        mframes = 0;
        mswapped = 1;
        mwaiting = 0;
      end
    end
  endtask

  function automatic bit rd_known(input logic [AW-1:0] a);
    return !mvalid || mknown[mshown][a];
  endfunction

  function automatic logic [DW-1:0] rd_expect(input logic [AW-1:0] a);
    return mvalid ? mlist[mshown][a] : '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
  endtask

  task automatic idle();
    wr_en = 0; wr_commit = 0; frame_drawn = 0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    tick(); tick();
    rst = 0;
    rd_addr = 8'h05;
    #1;
    checks++; if (rd_data !== 18'h0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    checks++; if (front_valid !== 1'b0) begin errors++; $display("FAIL reset_front_valid got %b want 0", front_valid); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL reset_front_sel got %b want 0", front_sel); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
    checks++; if (wr_err !== 1'b0 || swap_done !== 1'b0) begin errors++; $display("FAIL reset_pulses got err=%b swap=%b want 0 0", wr_err, swap_done); end
  endtask

  task automatic test_swap();
    do_write(8'h00, 18'h3A5A5);
    do_write(8'h01, 18'h00FFF);
    wr_commit = 1; tick(); wr_commit = 0;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL swap_wr_ready_fall got %b want 0", wr_ready); end
    tick(); tick();
    frame_drawn = 1; tick(); frame_drawn = 0;
    checks++; if (swap_done !== 1'b1) begin errors++; $display("FAIL swap_done got %b want 1", swap_done); end
    checks++; if (front_sel !== 1'b1) begin errors++; $display("FAIL swap_front_sel got %b want 1", front_sel); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL swap_frame_cnt got %0d want 0", frame_cnt); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL swap_wr_ready_rise got %b want 1", wr_ready); end
    rd_addr = 8'h00; #1;
    checks++; if (rd_data !== 18'h3A5A5) begin errors++; $display("FAIL swap_rd0 got %h want 3a5a5", rd_data); end
    rd_addr = 8'h01; #1;
    checks++; if (rd_data !== 18'h00FFF) begin errors++; $display("FAIL swap_rd1 got %h want 00fff", rd_data); end
    tick();
    checks++; if (swap_done !== 1'b0) begin errors++; $display("FAIL swap_done_single got %b want 0", swap_done); end
  endtask

  task automatic test_pending_reject();
    do_write(8'h00, 18'h2BEEF);
    wr_commit = 1; tick(); wr_commit = 0;
    wr_en = 1; wr_addr = 8'h00; wr_data = 18'h11111;
    tick(); wr_en = 0;
    checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL reject_wr_err got %b want 1", wr_err); end
    tick();
    checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL reject_wr_err_once got %b want 0", wr_err); end
    frame_drawn = 1; tick(); frame_drawn = 0;
    rd_addr = 8'h00; #1;
    checks++; if (rd_data !== 18'h2BEEF) begin errors++; $display("FAIL reject_rd0 got %h want 2beef", rd_data); end
    checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL reject_front_sel got %b want 0", front_sel); end
  endtask

  task automatic test_commit_with_frame();
    logic sel0;
    sel0 = front_sel;
    wr_commit = 1; frame_drawn = 1; tick(); idle();
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL cwf_wr_ready got %b want 0", wr_ready); end
    checks++; if (swap_done !== 1'b0 || front_sel !== sel0) begin errors++; $display("FAIL cwf_no_swap got swap=%b sel=%b want 0 %b", swap_done, front_sel, sel0); end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL cwf_frame_cnt got %0d want 1", frame_cnt); end
    tick();
    frame_drawn = 1; tick(); frame_drawn = 0;
    checks++; if (swap_done !== 1'b1 || front_sel === sel0) begin errors++; $display("FAIL cwf_late_swap got swap=%b sel=%b want 1 %b", swap_done, front_sel, !sel0); end
  endtask

  task automatic test_saturate();
    logic sel0;
    sel0 = front_sel;
    for (int i = 0; i < 300; i++) begin
      frame_drawn = 1; tick();
    end
    frame_drawn = 0;
    checks++; if (frame_cnt !== 8'd255) begin errors++; $display("FAIL sat_frame_cnt got %0d want 255", frame_cnt); end
    checks++; if (front_sel !== sel0) begin errors++; $display("FAIL sat_front_sel got %b want %b", front_sel, sel0); end
  endtask

  task automatic test_reset_pending();
    wr_commit = 1; tick(); wr_commit = 0;
    #2 rst = 1;
    #1;
    checks++; if (wr_ready !== 1'b1 || front_valid !== 1'b0 || front_sel !== 1'b0) begin errors++; $display("FAIL rstp_ctrl got rdy=%b vld=%b sel=%b want 1 0 0", wr_ready, front_valid, front_sel); end
    checks++; if (rd_data !== 18'h0) begin errors++; $display("FAIL rstp_rd_data got %h want 0", rd_data); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL rstp_frame_cnt got %0d want 0", frame_cnt); end
    tick();
    rst = 0;
    frame_drawn = 1; tick(); frame_drawn = 0;
    checks++; if (swap_done !== 1'b0 || front_valid !== 1'b0) begin errors++; $display("FAIL rstp_no_swap got swap=%b vld=%b want 0 0", swap_done, front_valid); end
    wr_commit = 1; tick(); wr_commit = 0;
    frame_drawn = 1; tick(); frame_drawn = 0;
    checks++; if (swap_done !== 1'b1 || front_valid !== 1'b1) begin errors++; $display("FAIL rstp_swap_after_commit got swap=%b vld=%b want 1 1", swap_done, front_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      wr_en       = ($urandom_range(0, 1) == 1);
      wr_addr     = AW'($urandom_range(0, 15));
      wr_data     = DW'($urandom);
      wr_commit   = ($urandom_range(0, 9) == 0);
      frame_drawn = ($urandom_range(0, 6) == 0);
      tick();
      checks++; if (wr_ready !== !mwaiting) begin errors++; $display("FAIL rnd_wr_ready cyc %0d got %b want %b", i, wr_ready, !mwaiting); end
      checks++; if (wr_err !== merr) begin errors++; $display("FAIL rnd_wr_err cyc %0d got %b want %b", i, wr_err, merr); end
      checks++; if (swap_done !== mswapped) begin errors++; $display("FAIL rnd_swap_done cyc %0d got %b want %b", i, swap_done, mswapped); end
      checks++; if (front_sel !== mshown || front_valid !== mvalid) begin errors++; $display("FAIL rnd_front cyc %0d got sel=%b vld=%b want %b %b", i, front_sel, front_valid, mshown, mvalid); end
      checks++; if (frame_cnt !== 8'(mframes)) begin errors++; $display("FAIL rnd_frame_cnt cyc %0d got %0d want %0d", i, frame_cnt, mframes); end
      rd_addr = AW'($urandom_range(0, 15));
      #1;
      if (rd_known(rd_addr)) begin
        checks++; if (rd_data !== rd_expect(rd_addr)) begin errors++; $display("FAIL rnd_rd_data cyc %0d addr %h got %h want %h", i, rd_addr, rd_data, rd_expect(rd_addr)); end
      end
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_swap();
    test_pending_reject();
    test_commit_with_frame();
    test_saturate();
    test_reset_pending();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vector_list_buffer.md
# vector_list_buffer

Double-buffered display-list RAM that replaces the fixed vector ROM as the data source for the vector display stage. Game/scene logic writes a new vector list into the back bank while the display reads the front bank; banks swap only at a frame boundary (`frame_drawn`), so no frame ever mixes two lists. Read side is pin-compatible with the ROM: address in, data out, combinational.

## Interface

Parameters:
- `ADDRESSWIDTH`, 8, bank address width; each bank holds 2^ADDRESSWIDTH words.
- `DATAWIDTH`, 18, vector word width, identical to the display's `data_in`.

Ports:
- `clk`  in  1  system clock, same clock as the vector display.
- `rst`  in  1  reset, asynchronous, active-high.
- `wr_en`  in  1  write strobe into the back bank.
- `wr_addr`  in  ADDRESSWIDTH  write address.
- `wr_data`  in  DATAWIDTH  write data.
- `wr_commit`  in  1  single-cycle pulse: back-bank list complete, request swap.
- `wr_ready`  out  1  back bank writable, no commit pending.
- `wr_err`  out  1  registered one-cycle pulse: `wr_en` or `wr_commit` rejected.
- `rd_addr`  in  ADDRESSWIDTH  read address from the vector display.
- `rd_data`  out  DATAWIDTH  front-bank word at `rd_addr`, combinational.
- `frame_drawn`  in  1  single-cycle pulse from the display at end of frame.
- `front_sel`  out  1  index of the bank currently displayed.
- `front_valid`  out  1  at least one swap has occurred since reset.
- `swap_done`  out  1  registered one-cycle pulse on the cycle after a swap.
- `frame_cnt`  out  8  frames completed on the current front list, saturating at 255.

## Operation

- Two states: `FILL` (wr_ready=1) and `PENDING` (wr_ready=0).
- FILL: `wr_en`=1 writes `wr_data` to bank `~front_sel` at `wr_addr` on the clock edge. `wr_commit`=1 moves to PENDING.
  - `wr_en` and `wr_commit` in the same cycle: the write lands, then the commit takes effect.
- PENDING: `frame_drawn`=1 on an edge causes the following, all on that edge:
  - `front_sel` toggles.
  - `front_valid` is set to 1.
  - `frame_cnt` clears to 0.
  - `swap_done` pulses.
  - State returns to FILL.
- PENDING: `wr_en` or `wr_commit` is ignored (no RAM change) and `wr_err` pulses next cycle.
- FILL with `wr_commit` and `frame_drawn` in the same cycle: go to PENDING, no swap. The swap waits for the next `frame_drawn`.
- `frame_drawn` in FILL, or in PENDING when not swapping: `frame_cnt` increments, saturating at 255.
- `rd_data` = front-bank word at `rd_addr` when `front_valid`=1; otherwise all zeros (blank list).
- New writes never alias the front bank. The back bank keeps stale data from two swaps earlier; the writer must rewrite every word the list uses.

## Timing

- Reset values: state FILL, `front_sel`=0, `front_valid`=0, `wr_ready`=1, `wr_err`=0, `swap_done`=0, `frame_cnt`=0. RAM contents are not reset.
- Reset asserted mid-operation drops any pending commit; `rd_data` returns to zeros immediately (combinational on `front_valid`).
- Write latency: 1 edge. The word is readable from the back bank only after a swap.
- Read latency: 0 cycles, combinational from `rd_addr`/`front_sel`.
- Swap: `rd_data` reflects the new bank in the cycle immediately after the `frame_drawn` edge, so the display's next frame (address 0) reads the new list.
- `wr_ready` falls the cycle after `wr_commit` and rises the cycle after the swapping `frame_drawn`.

## Structure

- `vector_pkg` gets `typedef enum logic {BUF_FILL, BUF_PENDING} vbuf_state_t` and `localparam VBUF_BLANK_WORD = '0`.
- Sub-module `vector_list_bank`: one 2^ADDRESSWIDTH x DATAWIDTH RAM, synchronous write, asynchronous read. Instantiated twice; write enable steered by `~front_sel`, read mux by `front_sel`.
- FSM, counters, pulse registers and the output mux stay in `vector_list_buffer`.

## Test plan

- Reset, no writes, `rd_addr`=0x05 → `rd_data`=0, `front_valid`=0, `wr_ready`=1, `front_sel`=0.
- Write 0x00→0x3A5A5 and 0x01→0x00FFF, then `wr_commit`, then `frame_drawn` 3 cycles later:
  - `swap_done` pulses and `front_sel`=1.
  - Reads at 0x00 and 0x01 return 0x3A5A5 and 0x00FFF the next cycle.
  - `frame_cnt`=0.
- In PENDING, `wr_en` at 0x00 with 0x11111 → `wr_err` pulses once; after the swap, 0x00 still reads the committed value.
- `wr_commit` and `frame_drawn` in the same cycle → no swap, `wr_ready`=0; the next `frame_drawn` swaps.
- 300 `frame_drawn` pulses with no commit → `frame_cnt` stays at 255 and `front_sel` is unchanged.
- `rst` asserted while PENDING → outputs immediately take reset values, `rd_data`=0, and `wr_commit` is needed again before any swap.
